// File: rtl/imem_boot_loader.sv
// imem_boot_loader: boot-time program loader for the instruction memory.
// Accepts a byte stream (16-bit word count, then little-endian words),
// writes the words sequentially into instruction RAM and holds the CPU
// off the fetch port while a session is active. Outside a session, CPU
// fetches pass straight through to the memory read port.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | no session; fetches pass through to memory
// S_LEN0  | waiting for word-count low byte
// S_LEN1  | waiting for word-count high byte; length is validated here
// S_DATA  | collecting the four bytes of the current word
// S_WRITE | one-cycle write of the assembled word
// S_DONE  | one-cycle completion pulse
// S_ERR   | illegal length; CPU held, no writes, waits for start

module imem_boot_loader #(
    parameter int DEPTH = 400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [31:0] cpu_instr_rAddr,
    output logic [31:0] cpu_instr_code,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int          IDX_W   = $clog2(DEPTH + 1);
    localparam logic [15:0] DEPTH_W = 16'(DEPTH);
    localparam logic [31:0] NOP     = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      len_q, len_d;
    logic [IDX_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;

    logic             rx_ready_q, rx_ready_d;
    logic             cpu_hold_q, cpu_hold_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic             mem_we_q, mem_we_d;
    logic [31:0]      mem_waddr_q, mem_waddr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             accept;
    logic [15:0]      len_full;
    logic [15:0]      idx_next;

    // rx_ready_q already reflects LEN0/LEN1/DATA, so it doubles as the handshake qualifier
    assign accept = rx_valid && rx_ready_q;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        len_full   = {rx_data, len_q[7:0]};
        idx_next   = 16'(word_idx_q) + 16'd1;

        unique case (state_q)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN0;
                    word_idx_d = '0;
                    byte_cnt_d = '0;
                end
            end
            S_LEN0: begin
                if (accept) begin
                    len_d   = {8'h00, rx_data};
                    state_d = S_LEN1;
                end
            end
            S_LEN1: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0 || len_full > DEPTH_W) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    case (byte_cnt_q)
                        2'd0:    word_d[7:0]   = rx_data;
                        2'd1:    word_d[15:8]  = rx_data;
                        2'd2:    word_d[23:16] = rx_data;
                        default: word_d[31:24] = rx_data;
                    endcase
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_idx_d = word_idx_q + IDX_W'(1);
                state_d    = (idx_next == len_q) ? S_DONE : S_DATA;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        rx_ready_d  = (state_d == S_LEN0) || (state_d == S_LEN1) || (state_d == S_DATA);
        cpu_hold_d  = (state_d != S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        error_d     = (state_d == S_ERR);
        mem_we_d    = (state_d == S_WRITE);
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        if (mem_we_d) begin
            mem_waddr_d = 32'(word_idx_q) << 2;
            mem_wdata_d = word_d;
        end
    end

    // State, counters and registered outputs with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            word_idx_q  <= '0;
            byte_cnt_q  <= '0;
            word_q      <= '0;
            rx_ready_q  <= 1'b0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            word_idx_q  <= word_idx_d;
            byte_cnt_q  <= byte_cnt_d;
            word_q      <= word_d;
            rx_ready_q  <= rx_ready_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign rx_ready  = rx_ready_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign mem_we    = mem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;

    // Fetch path: read port follows the CPU, data is replaced by NOP while held
    assign mem_raddr      = cpu_instr_rAddr;
    assign cpu_instr_code = cpu_hold_q ? NOP : mem_rdata;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Testbench for imem_boot_loader: streams programs (fixed and random) into the
// loader and compares writes, handshakes, timing and the fetch mux against a
// reference built directly from the stream format.

module tb_imem_boot_loader;

    localparam int          DEPTH = 400;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] cpu_instr_rAddr;
    logic [31:0] cpu_instr_code;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    logic [31:0] dut_mem [DEPTH];
    logic [7:0]  stream [$];
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];
    logic [31:0] exp_w [$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imem_boot_loader #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ready        (rx_ready),
        .cpu_instr_rAddr (cpu_instr_rAddr),
        .cpu_instr_code  (cpu_instr_code),
        .mem_raddr       (mem_raddr),
        .mem_rdata       (mem_rdata),
        .mem_we          (mem_we),
        .mem_waddr       (mem_waddr),
        .mem_wdata       (mem_wdata),
        .cpu_hold        (cpu_hold),
        .busy            (busy),
        .done            (done),
        .error           (error)
    );

    assign mem_rdata = (mem_raddr[31:2] < 30'(DEPTH)) ? dut_mem[mem_raddr[31:2]] : 32'hBAD0_BAD0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock; sample 1ns after the edge and log any write seen this cycle
    task automatic tick();
        @(posedge clk);
        #1;
        if (mem_we) begin
            wr_addr_q.push_back(mem_waddr);
            wr_data_q.push_back(mem_wdata);
            if (mem_waddr[31:2] < 30'(DEPTH)) dut_mem[mem_waddr[31:2]] = mem_wdata;
        end
    endtask

    task automatic build_stream(input int n_field, input int n_words);
        stream.delete();
        stream.push_back(8'(n_field));
        stream.push_back(8'(n_field >> 8));
        for (int i = 0; i < 4 * n_words; i++) stream.push_back(8'($urandom));
    endtask

    // gap_mode: 0 valid always, 1 valid on alternate cycles, 2 random valid
    task automatic run_stream(input int gap_mode, input bit extra_start, input int reset_after);
        int  n;
        bit  exp_err;
        int  ptr;
        int  c;
        int  ndone;
        int  done_c;
        bit  acc;
        int  idx;
        n       = int'({stream[1], stream[0]});
        exp_err = (n == 0) || (n > DEPTH);
        exp_w.delete();
        if (!exp_err) begin
            for (int i = 0; i < n; i++)
                exp_w.push_back({stream[4*i+5], stream[4*i+4], stream[4*i+3], stream[4*i+2]});
        end
        wr_addr_q.delete();
        wr_data_q.delete();

        rx_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_rx_ready", 32'(rx_ready), 32'd1);
        check_val("start_hold", 32'(cpu_hold), 32'd1);
        check_val("start_error_clr", 32'(error), 32'd0);

        ptr    = 0;
        c      = 0;
        ndone  = 0;
        done_c = -1;
        while (c < 4000) begin
            case (gap_mode)
                0:       rx_valid = 1'b1;
                1:       rx_valid = (c % 2 == 0);
                default: rx_valid = 1'($urandom_range(0, 1));
            endcase
            rx_data         = (ptr < stream.size()) ? stream[ptr] : 8'($urandom);
            cpu_instr_rAddr = $urandom;
            if (extra_start) start = ($urandom_range(0, 7) == 0);
            acc = rx_valid && rx_ready;
            tick();
            c++;
            start = 1'b0;
            if (acc) ptr++;
            check_val("session_nop", cpu_instr_code, NOP);
            if (done) begin
                ndone++;
                done_c = c + 1;
                break;
            end
            if (exp_err && c >= 8) break;
            if (reset_after > 0 && wr_data_q.size() == reset_after) break;
        end
        rx_valid = 1'b0;

        if (reset_after > 0) begin
            reset = 1'b1;
            tick();
            check_val("rst_hold", 32'(cpu_hold), 32'd0);
            check_val("rst_busy", 32'(busy), 32'd0);
            check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
            reset = 1'b0;
            for (int i = 0; i < 8; i++) begin
                rx_valid = 1'b1;
                rx_data  = 8'($urandom);
                tick();
                if (done) ndone++;
            end
            rx_valid = 1'b0;
            check_val("rst_no_done", 32'(ndone), 32'd0);
            check_val("rst_wr_count", 32'(wr_data_q.size()), 32'(reset_after));
            check_val("rst_wr_addr0", wr_addr_q[0], 32'd0);
            check_val("rst_wr_data0", wr_data_q[0], exp_w[0]);
        end else if (exp_err) begin
            check_val("err_flag", 32'(error), 32'd1);
            check_val("err_hold", 32'(cpu_hold), 32'd1);
            check_val("err_busy", 32'(busy), 32'd1);
            check_val("err_rx_ready", 32'(rx_ready), 32'd0);
            check_val("err_wr_count", 32'(wr_data_q.size()), 32'd0);
            check_val("err_bytes_used", 32'(ptr), 32'd2);
            check_val("err_no_done", 32'(ndone), 32'd0);
        end else begin
            check_val("done_count", 32'(ndone), 32'd1);
            if (gap_mode == 0) check_val("done_cycle", 32'(done_c), 32'(2 + 5 * n + 1));
            check_val("wr_count", 32'(wr_data_q.size()), 32'(n));
            for (int i = 0; i < n && i < wr_data_q.size(); i++) begin
                check_val("wr_addr", wr_addr_q[i], 32'(i * 4));
                check_val("wr_data", wr_data_q[i], exp_w[i]);
            end
            check_val("bytes_used", 32'(ptr), 32'(4 * n + 2));
            tick();
            check_val("post_hold", 32'(cpu_hold), 32'd0);
            check_val("post_busy", 32'(busy), 32'd0);
            check_val("post_done", 32'(done), 32'd0);
            check_val("post_wr_count", 32'(wr_data_q.size()), 32'(n));
            for (int k = 0; k < 3; k++) begin
                idx = (k == 0) ? 0 : $urandom_range(0, n - 1);
                cpu_instr_rAddr = 32'(idx * 4);
                #1;
                check_val("fetch_raddr", mem_raddr, 32'(idx * 4));
                check_val("fetch_code", cpu_instr_code, exp_w[idx]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) dut_mem[i] = 32'h0;
        dut_mem[2]      = 32'hDEAD_BEEF;
        reset           = 1'b1;
        start           = 1'b0;
        rx_valid        = 1'b0;
        rx_data         = 8'h00;
        cpu_instr_rAddr = 32'd8;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check_val("rst_rx_ready", 32'(rx_ready), 32'd0);
        check_val("rst_mem_we", 32'(mem_we), 32'd0);
        check_val("rst_waddr", mem_waddr, 32'd0);
        check_val("rst_wdata", mem_wdata, 32'd0);
        check_val("rst_hold0", 32'(cpu_hold), 32'd0);
        check_val("rst_busy0", 32'(busy), 32'd0);
        check_val("rst_done0", 32'(done), 32'd0);
        check_val("rst_error0", 32'(error), 32'd0);
        check_val("rst_raddr", mem_raddr, 32'd8);
        check_val("rst_fetch", cpu_instr_code, 32'hDEAD_BEEF);

        stream = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00, 8'h93, 8'h05, 8'h60, 8'h00};
        run_stream(0, 1'b0, 0);
        run_stream(1, 1'b1, 0);

        stream = '{8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(0, 1'b0, 0);
        stream = '{8'h91, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_stream(2, 1'b0, 0);

        build_stream(1, 1);
        run_stream(0, 1'b0, 0);
        build_stream(DEPTH, DEPTH);
        run_stream(0, 1'b0, 0);

        build_stream(3, 3);
        run_stream(0, 1'b0, 1);

        for (int t = 0; t < 6; t++) begin
            build_stream($urandom_range(1, 8), 8);
            run_stream(2, 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
